spi_mcu_link: RTL
=================

// Module: spi_mcu_link
// PURPOSE
//  Parametrised successor to the NDN<->MCU serial port. Router is slave, MCU is master.
//  Deframes interest packets from the MCU on mosi into a one-entry PIT-side holding register.
//  Serialises data packets from the PIT onto miso.
//  valid/ready handshakes on both sides replace the single-cycle flag.
// PARAMETERS
//  PREFIX_W    64  prefix field width, bits
//  LEN_W       6   prefix-length field width, bits
//  DATA_BYTES  32  data payload bytes per data packet (payload = DATA_BYTES*8 bits)
// PORTS
//  clk            in   1                 system clock; one bit per cycle on mosi/miso
//  rst            in   1                 asynchronous, active-low reset
//  cs             in   1                 active-low select from MCU; gates RX only
//  mosi           in   1                 serial in from MCU, idle high
//  miso           out  1                 serial out to MCU, idle high
//  rx_valid       out  1                 interest held for PIT
//  rx_ready       in   1                 PIT accepts interest
//  rx_length      out  LEN_W             received prefix length
//  rx_prefix      out  PREFIX_W          received prefix
//  rx_frame_err   out  1                 1-cycle pulse: bad stop bit or cs abort
//  rx_overflow    out  1                 1-cycle pulse: good frame dropped, holding reg full
//  rx_parity_err  out  1                 1-cycle pulse: parity mismatch (0 unless MCU_PARITY_EN)
//  tx_valid       in   1                 PIT offers data packet
//  tx_ready       out  1                 transmitter idle, can accept
//  tx_prefix      in   PREFIX_W          data packet name
//  tx_data        in   DATA_BYTES*8      payload; MSB byte sent first
//  tx_busy        out  1                 frame on miso in progress
// BEHAVIOUR
//  Reset (rst=0, async): both FSMs idle; all counters 0.
//   Output values: miso=1, rx_valid=0, rx_length=0, rx_prefix=0, all error pulses 0,
//   tx_ready=1, tx_busy=0.
//  Bit order: all fields MSB first, one bit per clk.
//  RX frame: start(0), type(1=interest), LEN_W length, PREFIX_W prefix, [parity], stop(1).
//   Default frame length: 73 bits (74 with parity).
//  RX FSM: R_IDLE -> R_TYPE -> R_LEN -> R_PFX -> [R_PAR] -> R_STOP -> R_IDLE.
//   R_IDLE leaves on mosi=0 sampled while cs=0.
//   Type bit 0 (data packet from MCU): frame shifted in but discarded silently.
//     No rx_valid and no error pulse for such frames.
//   R_STOP with mosi=0: rx_frame_err, frame discarded.
//   cs=1 in any non-idle RX state: abort to R_IDLE, rx_frame_err. Partial data never appears.
//  Holding reg: loaded the cycle after a good stop bit; rx_valid rises that same cycle.
//   rx_valid/rx_length/rx_prefix are stable until the cycle after rx_valid&rx_ready.
//   Good frame while rx_valid=1 and rx_ready=0: dropped, rx_overflow pulse, held entry kept.
//   Simultaneous pop (rx_ready=1) and new load: load wins, rx_valid stays 1, no overflow.
//  TX frame: start(0), type(0), PREFIX_W prefix, DATA_BYTES*8 data, [parity], stop(1).
//   Default frame length: 323 bits (324 with parity).
//  TX FSM: T_IDLE -> T_START -> T_TYPE -> T_PFX -> T_DATA -> [T_PAR] -> T_STOP -> T_IDLE.
//   Handshake tx_valid&tx_ready in T_IDLE latches tx_prefix/tx_data into a shift register.
//   Inputs may change after that cycle.
//   Timing: miso=0 on the cycle after the handshake. tx_ready=0 and tx_busy=1 from then
//   through the stop bit. tx_ready=1 the cycle after the stop bit.
//   Back-to-back frames allowed: one idle-high cycle between them.
//   TX ignores cs; RX and TX run fully independently (full duplex).
//  Counters are sized by $clog2 of the field width. No wrap: each count ends at 0 and the
//   state changes. All parameter widths must be >=1.
// CONFIGURATION
//  MCU_PARITY_EN defined:
//   TX inserts an even-parity bit over type+prefix+data before stop.
//   RX expects an even-parity bit over type+length+prefix before stop.
//   RX mismatch: rx_parity_err pulse, frame discarded (takes precedence over overflow).
//  MCU_PARITY_EN undefined: no parity bit in either direction; rx_parity_err tied 0.
// TESTING
//  1. RX interest, len=6'd12, prefix=64'hDEAD_BEEF_0123_4567, rx_ready=1 ->
//     rx_valid 1 cycle after stop, fields exact, pulse cleared next cycle.
//  2. Two good frames, rx_ready=0 ->
//     first held unchanged, rx_overflow pulses once at second stop.
//  3. RX frame with stop bit 0, then cs=1 at bit 20 of the next frame ->
//     two rx_frame_err pulses, rx_valid never asserts.
//  4. TX prefix=64'h0102_0304_0506_0708, data=256'hA5 repeated ->
//     miso low 1 cycle after handshake, 323 bits match, tx_ready=1 after stop.
//  5. tx_valid held high continuously -> frames separated by exactly one idle-high cycle.
//  6. rst=0 mid-TX at bit 100 -> miso=1 and tx_ready=1 immediately (async).
//     With MCU_PARITY_EN: a corrupted parity bit gives rx_parity_err and drops the frame.

Source files
------------

// File: rtl/spi_mcu_link.sv
// NDN router <-> MCU serial link: router is the slave. It deframes interests from mosi into a
// one-entry holding register and serialises PIT data packets onto miso. Optional macro MCU_PARITY_EN.
module spi_mcu_link #(
  parameter int PREFIX_W   = 64,
  parameter int LEN_W      = 6,
  parameter int DATA_BYTES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [LEN_W-1:0]        rx_length,
  output logic [PREFIX_W-1:0]     rx_prefix,
  output logic                    rx_frame_err,
  output logic                    rx_overflow,
  output logic                    rx_parity_err,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [PREFIX_W-1:0]     tx_prefix,
  input  logic [DATA_BYTES*8-1:0] tx_data,
  output logic                    tx_busy
);

  localparam int DATA_W = DATA_BYTES * 8;
  localparam int SH_W   = PREFIX_W + DATA_W;
  localparam int MAX_PL = (PREFIX_W > LEN_W) ? PREFIX_W : LEN_W;
  localparam int MAX_W  = (DATA_W > MAX_PL) ? DATA_W : MAX_PL;
  localparam int CW     = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  localparam logic [2:0] R_IDLE = 3'd0;
  localparam logic [2:0] R_TYPE = 3'd1;
  localparam logic [2:0] R_LEN  = 3'd2;
  localparam logic [2:0] R_PFX  = 3'd3;
  localparam logic [2:0] R_PAR  = 3'd4;
  localparam logic [2:0] R_STOP = 3'd5;

  localparam logic [2:0] T_IDLE  = 3'd0;
  localparam logic [2:0] T_START = 3'd1;
  localparam logic [2:0] T_TYPE  = 3'd2;
  localparam logic [2:0] T_PFX   = 3'd3;
  localparam logic [2:0] T_DATA  = 3'd4;
  localparam logic [2:0] T_PAR   = 3'd5;
  localparam logic [2:0] T_STOP  = 3'd6;

  logic [2:0]          r_rx_state;
  logic [CW-1:0]       r_rx_cnt;
  logic                r_rx_type;
  logic                r_rx_valid;
  logic [LEN_W-1:0]    r_rx_length;
  logic [PREFIX_W-1:0] r_rx_prefix;
  logic                r_rx_ferr;
  logic                r_rx_ovf;
  logic [LEN_W-1:0]    r_rx_len_sh;
  logic [PREFIX_W-1:0] r_rx_pfx_sh;

  logic [2:0]          r_tx_state;
  logic [CW-1:0]       r_tx_cnt;
  logic [SH_W-1:0]     r_tx_sh;
  logic                w_tx_ready;
  logic                w_tx_hs;
  logic                w_miso;

`ifdef MCU_PARITY_EN
  logic                r_rx_par;
  logic                r_rx_par_bad;
  logic                r_rx_perr;
  logic                r_tx_par;
`endif

  assign w_tx_ready = (r_tx_state == T_IDLE);
  assign w_tx_hs    = tx_valid && w_tx_ready;

  assign rx_valid     = r_rx_valid;
  assign rx_length    = r_rx_length;
  assign rx_prefix    = r_rx_prefix;
  assign rx_frame_err = r_rx_ferr;
  assign rx_overflow  = r_rx_ovf;
  assign tx_ready     = w_tx_ready;
  assign tx_busy      = !w_tx_ready;
  assign miso         = w_miso;
`ifdef MCU_PARITY_EN
  assign rx_parity_err = r_rx_perr;
`else
  assign rx_parity_err = 1'b0;
`endif

  // RX deframer and holding register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state  <= R_IDLE;
      r_rx_cnt    <= '0;
      r_rx_type   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_length <= '0;
      r_rx_prefix <= '0;
      r_rx_ferr   <= 1'b0;
      r_rx_ovf    <= 1'b0;
`ifdef MCU_PARITY_EN
      r_rx_perr   <= 1'b0;
`endif
    end else begin
      r_rx_ferr <= 1'b0;
      r_rx_ovf  <= 1'b0;
`ifdef MCU_PARITY_EN
      r_rx_perr <= 1'b0;
`endif
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (r_rx_state != R_IDLE && cs) begin
        r_rx_state <= R_IDLE;
        r_rx_ferr  <= 1'b1;
      end else begin
        case (r_rx_state)
          R_IDLE: if (!cs && !mosi) r_rx_state <= R_TYPE;
          R_TYPE: begin
            r_rx_type  <= mosi;
            r_rx_cnt   <= CW'(LEN_W - 1);
            r_rx_state <= R_LEN;
          end
          R_LEN: begin
            if (r_rx_cnt == '0) begin
              r_rx_cnt   <= CW'(PREFIX_W - 1);
              r_rx_state <= R_PFX;
            end else begin
              r_rx_cnt <= r_rx_cnt - CW'(1);
            end
          end
          R_PFX: begin
            if (r_rx_cnt == '0) begin
`ifdef MCU_PARITY_EN
              r_rx_state <= R_PAR;
`else
              r_rx_state <= R_STOP;
`endif
            end else begin
              r_rx_cnt <= r_rx_cnt - CW'(1);
            end
          end
          R_PAR: r_rx_state <= R_STOP;
          R_STOP: begin
            r_rx_state <= R_IDLE;
            if (!mosi) begin
              r_rx_ferr <= 1'b1;
            end else if (r_rx_type) begin
`ifdef MCU_PARITY_EN
              if (r_rx_par_bad) r_rx_perr <= 1'b1;
              else
`endif
              if (r_rx_valid && !rx_ready) begin
                r_rx_ovf <= 1'b1;
              end else begin
                // a pop in this same cycle is overridden by the new load
                r_rx_valid  <= 1'b1;
                r_rx_length <= r_rx_len_sh;
                r_rx_prefix <= r_rx_pfx_sh;
              end
            end
          end
          default: r_rx_state <= R_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_rx_state == R_LEN) r_rx_len_sh <= LEN_W'({r_rx_len_sh, mosi});
    if (r_rx_state == R_PFX) r_rx_pfx_sh <= PREFIX_W'({r_rx_pfx_sh, mosi});
    if (w_tx_hs)
      r_tx_sh <= {tx_prefix, tx_data};
    else if (r_tx_state == T_PFX || r_tx_state == T_DATA)
      r_tx_sh <= SH_W'({r_tx_sh, 1'b0});
  end

`ifdef MCU_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_par     <= 1'b0;
      r_rx_par_bad <= 1'b0;
      r_tx_par     <= 1'b0;
    end else begin
      case (r_rx_state)
        R_IDLE:               r_rx_par     <= 1'b0;
        R_TYPE, R_LEN, R_PFX: r_rx_par     <= r_rx_par ^ mosi;
        R_PAR:                r_rx_par_bad <= r_rx_par ^ mosi;
        default: ;
      endcase
      // type bit is always 0 on TX, so it never changes the parity
      if (r_tx_state == T_IDLE)
        r_tx_par <= 1'b0;
      else if (r_tx_state == T_PFX || r_tx_state == T_DATA)
        r_tx_par <= r_tx_par ^ r_tx_sh[SH_W-1];
    end
  end
`endif

  // TX serialiser
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= T_IDLE;
      r_tx_cnt   <= '0;
    end else begin
      case (r_tx_state)
        T_IDLE:  if (tx_valid) r_tx_state <= T_START;
        T_START: r_tx_state <= T_TYPE;
        T_TYPE: begin
          r_tx_cnt   <= CW'(PREFIX_W - 1);
          r_tx_state <= T_PFX;
        end
        T_PFX: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= CW'(DATA_W - 1);
            r_tx_state <= T_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - CW'(1);
          end
        end
        T_DATA: begin
          if (r_tx_cnt == '0) begin
`ifdef MCU_PARITY_EN
            r_tx_state <= T_PAR;
`else
            r_tx_state <= T_STOP;
`endif
          end else begin
            r_tx_cnt <= r_tx_cnt - CW'(1);
          end
        end
        T_PAR:   r_tx_state <= T_STOP;
        T_STOP:  r_tx_state <= T_IDLE;
        default: r_tx_state <= T_IDLE;
      endcase
    end
  end

  // miso is decoded from state so reset forces the idle-high level immediately
  always_comb begin
    w_miso = 1'b1;
    case (r_tx_state)
      T_START, T_TYPE: w_miso = 1'b0;
      T_PFX, T_DATA:   w_miso = r_tx_sh[SH_W-1];
`ifdef MCU_PARITY_EN
      T_PAR:           w_miso = r_tx_par;
`else
      T_PAR:           w_miso = 1'b1;
`endif
      default:         w_miso = 1'b1;
    endcase
  end

endmodule
